// File: rtl/iccm_port_arbiter.sv
// ============================================================================
//  Module      : iccm_port_arbiter
//  Description : Two-port round-robin arbiter in front of a single-port DFFRAM
//                ICCM, with starvation override and 1-cycle tagged read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int MAX_STALL = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            p0_req_i,
    input  logic            p0_we_i,
    input  logic [AW-1:0]   p0_addr_i,
    input  logic [DW-1:0]   p0_wdata_i,
    input  logic [DW/8-1:0] p0_be_i,
    output logic            p0_gnt_o,
    output logic            p0_rvalid_o,
    output logic [DW-1:0]   p0_rdata_o,

    input  logic            p1_req_i,
    input  logic            p1_we_i,
    input  logic [AW-1:0]   p1_addr_i,
    input  logic [DW-1:0]   p1_wdata_i,
    input  logic [DW/8-1:0] p1_be_i,
    output logic            p1_gnt_o,
    output logic            p1_rvalid_o,
    output logic [DW-1:0]   p1_rdata_o,

    output logic            mem_en_o,
    output logic [DW/8-1:0] mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    localparam logic [0:0] PRIO_P0 = 1'b0;
    localparam logic [0:0] PRIO_P1 = 1'b1;

    logic [0:0]    prio_q, prio_d;
    logic [SW-1:0] stall0_q, stall0_d;
    logic [SW-1:0] stall1_q, stall1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic sat0, sat1, p0_wins;
    logic gnt0, gnt1;

    // A saturated port beats round robin unless both are saturated.
    always_comb begin
        sat0 = (stall0_q == STALL_MAX);
        sat1 = (stall1_q == STALL_MAX);
        if (sat0 && !sat1) begin
            p0_wins = 1'b1;
        end else if (sat1 && !sat0) begin
            p0_wins = 1'b0;
        end else begin
            p0_wins = (prio_q == PRIO_P0);
        end
        gnt0 = p0_req_i & ~rst_i & (~p1_req_i | p0_wins);
        gnt1 = p1_req_i & ~rst_i & (~p0_req_i | ~p0_wins);
    end

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = PRIO_P1;
        end else if (gnt1) begin
            prio_d = PRIO_P0;
        end

        stall0_d = '0;
        if (p0_req_i && !gnt0) begin
            stall0_d = sat0 ? stall0_q : stall0_q + SW'(1);
        end
        stall1_d = '0;
        if (p1_req_i && !gnt1) begin
            stall1_d = sat1 ? stall1_q : stall1_q + SW'(1);
        end

        rvalid0_d = gnt0 & ~p0_we_i;
        rvalid1_d = gnt1 & ~p1_we_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q    <= PRIO_P0;
            stall0_q  <= '0;
            stall1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            stall0_q  <= stall0_d;
            stall1_q  <= stall1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Only the granted port's address/data may reach the macro.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p0_we_i ? p0_be_i : '0;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end else if (gnt1) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p1_we_i ? p1_be_i : '0;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    assign p0_rvalid_o = rvalid0_q;
    assign p1_rvalid_o = rvalid1_q;
    assign p0_rdata_o  = rvalid0_q ? mem_rdata_i : '0;
    assign p1_rdata_o  = rvalid1_q ? mem_rdata_i : '0;

endmodule

`default_nettype wire
